// File: rtl/inst_fetch_bank_pkg.sv
// Shared definitions for the instruction fetch bank: FIFO depth default,
// FSM state encoding, boot/exception vectors and the FIFO entry layout.
package inst_fetch_bank_pkg;

    localparam int DEPTH_DEFAULT = 4;

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_WAIT   = 2'd1;  // one request outstanding
    localparam logic [1:0] ST_CANCEL = 2'd2;  // outstanding request to be dropped

    localparam logic [31:0] RESET_ADDR = 32'hbfc0_0000;
    localparam logic [31:0] EXEC_ADDR  = 32'hbfc0_0380;

    // One buffered instruction: the PC it was fetched from and the word itself
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_bank_fetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries. Pointers wrap modulo DEPTH
// (DEPTH must be a power of two, at least 2); count has one extra bit so a
// full buffer is distinguishable from an empty one. clear wins over push/pop.
module fetch_fifo
    import inst_fetch_bank_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as zero while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

    // Space is reserved when the address is issued, so a push into a full buffer
    // means the request gating upstream is broken.
    push_never_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));

endmodule

// File: rtl/inst_fetch_bank.sv
// Instruction fetch bank: issues SRAM-like instruction requests (one at a time),
// buffers returned words with their PCs in fetch_fifo, and presents the oldest
// entry to decode. flush discards everything buffered and any in-flight reply.
//
// Handshakes:
//   address: inst_req is the valid, inst_addr_ok the ready; the address transfers
//            on a clock edge where both are 1, and only then may the pc advance
//            (fetch_stall is the inverse of that transfer).
//   data:    inst_data_ok marks the reply to the single outstanding request; it is
//            consumed whenever the FSM is in WAIT or CANCEL and ignored in IDLE.
//   decode:  id_valid is the valid, !pd_id_stall the ready; the head entry is
//            consumed on an edge where both are 1 and flush is 0, and it stays
//            stable otherwise.
module inst_fetch_bank
    import inst_fetch_bank_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fetch_stall,
    output logic        inst_bank_valid,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        pd_id_stall,
    output logic [1:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic [31:0]  req_pc;
    logic [AW:0]  count;
    logic         addr_hs;
    logic         push;
    logic         pop;
    fetch_entry_t push_data;
    fetch_entry_t head;

    // A request is only issued when a slot is free, which is what keeps pushes
    // from ever overflowing the buffer. Reset holds the request low directly.
    assign inst_addr   = npc;
    assign inst_req    = !reset && (state == ST_IDLE) && !flush && (count < FULL);
    assign addr_hs     = inst_req && inst_addr_ok;
    assign fetch_stall = !addr_hs;

    assign push      = (state == ST_WAIT) && inst_data_ok && !flush;
    assign push_data = '{pc: req_pc, inst: inst_rdata};

    assign id_valid        = (count != '0);
    assign inst_bank_valid = id_valid;
    assign pop             = id_valid && !pd_id_stall && !flush;

    assign id_pc     = head.pc;
    assign id_inst   = head.inst;
    assign state_dbg = state;

    // Next-state logic for the single-outstanding-request fetch FSM
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (addr_hs) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // data arriving with flush is simply dropped; without data the
                // reply is still owed and must be swallowed later
                if (inst_data_ok)  state_nxt = ST_IDLE;
                else if (flush)    state_nxt = ST_CANCEL;
            end
            ST_CANCEL: begin
                if (inst_data_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register and the PC of the request currently in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (addr_hs) req_pc <= npc;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_fetch_bank.sv
// Bench for inst_fetch_bank: a pc/memory environment process, a decode-side
// monitor that scores every consumed head entry against an expected queue,
// and a directed main sequence.
module tb_inst_fetch_bank;
    import inst_fetch_bank_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_stall;
    logic        inst_bank_valid;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        pd_id_stall;
    logic [1:0]  state_dbg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    inst_fetch_bank #(.DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .npc             (npc),
        .flush           (flush),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .fetch_stall     (fetch_stall),
        .inst_bank_valid (inst_bank_valid),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .pd_id_stall     (pd_id_stall),
        .state_dbg       (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] redir_pc;
    int          mem_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_ADDR) return 32'h2401_0001;
        return {16'h2400, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    // ---------------- pc block and memory model ----------------
    // Samples at the negedge, applies just after the next posedge.
    initial begin : env
        logic        s_rst, s_flush, s_adv, s_acc;
        logic [31:0] s_addr, s_redir, paddr;
        int          s_lat, wcnt;
        logic        pend;
        npc          = RESET_ADDR;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        pend         = 1'b0;
        wcnt         = 0;
        paddr        = '0;
        forever begin
            @(negedge clk);
            s_rst   = reset;
            s_flush = flush;
            s_adv   = !fetch_stall;
            s_acc   = inst_req && inst_addr_ok;
            s_addr  = inst_addr;
            s_redir = redir_pc;
            s_lat   = mem_lat;
            @(posedge clk);
            #1;
            if (s_rst)        npc = RESET_ADDR;
            else if (s_flush) npc = s_redir;
            else if (s_adv)   npc = npc + 32'd4;
            inst_data_ok = 1'b0;
            if (pend) begin
                wcnt--;
                if (wcnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(paddr);
                    pend         = 1'b0;
                end
            end
            if (s_acc) begin
                paddr = s_addr;
                if (s_lat <= 1) begin
                    inst_data_ok = 1'b1;
                    inst_rdata   = mem_word(paddr);
                end else begin
                    pend = 1'b1;
                    wcnt = s_lat - 1;
                end
            end
        end
    end

    // ---------------- monitor: scores every consumed head entry ----------------
    always @(negedge clk) begin
        if (!reset && id_valid && !pd_id_stall && !flush) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {id_pc, id_inst}, 64'd0);
            end else begin
                check("pop_entry", {id_pc, id_inst}, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || id_valid) && n < 60) begin
            tick();
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, (exp_q.size() == 0 && !id_valid)}, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int n_acc;
        int cyc;
        reset        = 1'b1;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        pd_id_stall  = 1'b0;
        redir_pc     = '0;
        mem_lat      = 1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_req", inst_req, 0);
        check("rst_fetch_stall", fetch_stall, 1);
        check("rst_id_valid", id_valid, 0);
        check("rst_bank_valid", inst_bank_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_inst", id_inst, 0);
        check("rst_state", state_dbg, ST_IDLE);

        // single fetch, data two cycles after the address
        tick(); reset = 1'b0; inst_addr_ok = 1'b1; mem_lat = 2;
        @(negedge clk);
        check("t1_req", inst_req, 1);
        check("t1_addr", inst_addr, RESET_ADDR);
        check("t1_stall", fetch_stall, 0);
        expect_entry(RESET_ADDR);
        tick(); inst_addr_ok = 1'b0;
        @(negedge clk);
        check("t1_wait_req", inst_req, 0);
        check("t1_wait_state", state_dbg, ST_WAIT);
        tick();
        @(negedge clk);
        check("t1_valid_early", id_valid, 0);
        tick();
        @(negedge clk);
        check("t1_valid", id_valid, 1);
        check("t1_id_pc", id_pc, RESET_ADDR);
        check("t1_id_inst", id_inst, 32'h2401_0001);
        tick();
        @(negedge clk);
        check("t1_empty", id_valid, 0);

        // decode stalled, memory always ready: buffer fills to 4 then stops
        for (int i = 1; i <= 4; i++) expect_entry(RESET_ADDR + 32'(4 * i));
        tick(); inst_addr_ok = 1'b1; pd_id_stall = 1'b1; mem_lat = 1;
        repeat (11) tick();
        @(negedge clk);
        check("t2_full_req", inst_req, 0);
        check("t2_full_stall", fetch_stall, 1);
        check("t2_head_pc", id_pc, 32'hbfc0_0004);
        check("t2_head_inst", id_inst, mem_word(32'hbfc0_0004));
        tick(); inst_addr_ok = 1'b0; pd_id_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            check("t2_pop_valid", id_valid, 1);
        end
        tick();
        @(negedge clk);
        check("t2_drained", id_valid, 0);
        check("t2_qempty", exp_q.size(), 0);

        // flush while waiting, reply three cycles later is dropped
        expect_entry(EXEC_ADDR);
        tick(); inst_addr_ok = 1'b1; mem_lat = 4;
        @(negedge clk);
        check("t3_addr", inst_addr, 32'hbfc0_0014);
        check("t3_req", inst_req, 1);
        tick(); inst_addr_ok = 1'b0; flush = 1'b1; redir_pc = EXEC_ADDR;
        @(negedge clk);
        check("t3_flush_state", state_dbg, ST_WAIT);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t3_cancel", state_dbg, ST_CANCEL);
        check("t3_cancel_req", inst_req, 0);
        tick();
        @(negedge clk);
        check("t3_cancel_req2", inst_req, 0);
        tick();
        @(negedge clk);
        check("t3_drop_state", state_dbg, ST_CANCEL);
        check("t3_drop_valid", id_valid, 0);
        tick(); inst_addr_ok = 1'b1; mem_lat = 2;
        @(negedge clk);
        check("t3_idle", state_dbg, ST_IDLE);
        check("t3_new_addr", inst_addr, EXEC_ADDR);
        check("t3_new_req", inst_req, 1);
        check("t3_no_push", id_valid, 0);
        tick(); inst_addr_ok = 1'b0;
        drain("t3_drain");

        // flush in the same cycle as data_ok: nothing pushed
        tick(); inst_addr_ok = 1'b1; mem_lat = 2;
        @(negedge clk);
        check("t4_addr", inst_addr, 32'hbfc0_0384);
        tick(); inst_addr_ok = 1'b0;
        tick(); flush = 1'b1; redir_pc = 32'hbfc0_0400;
        @(negedge clk);
        check("t4_data_ok", inst_data_ok, 1);
        check("t4_state", state_dbg, ST_WAIT);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t4_idle", state_dbg, ST_IDLE);
        check("t4_valid", id_valid, 0);
        check("t4_bank_valid", inst_bank_valid, 0);
        check("t4_req", inst_req, 1);
        check("t4_addr_redir", inst_addr, 32'hbfc0_0400);

        // flush while idle: no request that cycle, resume at redirected npc
        tick(); flush = 1'b1; inst_addr_ok = 1'b1; redir_pc = 32'hbfc0_0500; mem_lat = 2;
        @(negedge clk);
        check("t4i_req", inst_req, 0);
        check("t4i_stall", fetch_stall, 1);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t4i_resume_req", inst_req, 1);
        check("t4i_resume_addr", inst_addr, 32'hbfc0_0500);
        check("t4i_resume_stall", fetch_stall, 0);
        expect_entry(32'hbfc0_0500);
        tick(); inst_addr_ok = 1'b0;
        drain("t4i_drain");

        // flush with entries buffered clears the buffer
        tick(); pd_id_stall = 1'b1; inst_addr_ok = 1'b1; mem_lat = 1;
        repeat (4) tick();
        @(negedge clk);
        check("t5_filled", inst_bank_valid, 1);
        tick(); flush = 1'b1; inst_addr_ok = 1'b0; redir_pc = 32'hbfc0_1000;
        @(negedge clk);
        check("t5_flush_state", state_dbg, ST_WAIT);
        tick(); flush = 1'b0; pd_id_stall = 1'b0;
        @(negedge clk);
        check("t5_cleared", inst_bank_valid, 0);
        check("t5_id_valid", id_valid, 0);
        check("t5_state", state_dbg, ST_IDLE);
        check("t5_addr", inst_addr, 32'hbfc0_1000);

        // continuous stream of 10 fetches with random decode stalls
        for (int i = 0; i < 10; i++) expect_entry(32'hbfc0_1000 + 32'(4 * i));
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10 && cyc < 300) begin
            tick();
            inst_addr_ok = 1'b1;
            pd_id_stall  = 1'($urandom_range(0, 1));
            mem_lat      = $urandom_range(1, 3);
            @(negedge clk);
            if (inst_req && inst_addr_ok) n_acc++;
            cyc++;
        end
        check("t6_accepts", n_acc, 10);
        tick(); inst_addr_ok = 1'b0; pd_id_stall = 1'b0;
        drain("t6_drain");

        // reset asserted while a request is outstanding
        tick(); pd_id_stall = 1'b1; inst_addr_ok = 1'b1; mem_lat = 1;
        tick(); inst_addr_ok = 1'b0;
        tick(); inst_addr_ok = 1'b1; mem_lat = 4;
        tick(); inst_addr_ok = 1'b0;
        check("t7_pre_state", state_dbg, ST_WAIT);
        check("t7_pre_valid", id_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_req", inst_req, 0);
        check("t7_rst_stall", fetch_stall, 1);
        check("t7_rst_valid", id_valid, 0);
        check("t7_rst_bank", inst_bank_valid, 0);
        check("t7_rst_pc", id_pc, 0);
        check("t7_rst_inst", id_inst, 0);
        check("t7_rst_state", state_dbg, ST_IDLE);
        tick(); reset = 1'b0; pd_id_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t7_late_valid", id_valid, 0);
            check("t7_late_state", state_dbg, ST_IDLE);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
